// File: rtl/reg_file_mp.sv
// Multi-port register file: three bypassed read ports, two write-back ports,
// self-incrementing PC, masked-update CPSR and a pending-write scoreboard.
module reg_file_mp #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 4,
    parameter logic [DATA_W-1:0]  RESET_PC = '0,
    parameter logic [DATA_W-1:0]  PC_INC   = DATA_W'(1),
    parameter bit                 ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_stall,
    output logic [DATA_W-1:0] if_pc_out,
    input  logic [ADDR_W-1:0] exe_rd_num,
    input  logic [ADDR_W-1:0] exe_rs_num,
    input  logic [ADDR_W-1:0] exe_rt_num,
    output logic [DATA_W-1:0] exe_rd_data_out,
    output logic [DATA_W-1:0] exe_rs_data_out,
    output logic [DATA_W-1:0] exe_rt_data_out,
    output logic              exe_rd_busy,
    output logic              exe_rs_busy,
    output logic              exe_rt_busy,
    input  logic              exe_issue_en,
    input  logic [ADDR_W-1:0] exe_issue_num,
    output logic [DATA_W-1:0] exe_cpsr_out,
    input  logic              wb0_write_en,
    input  logic [ADDR_W-1:0] wb0_rd_num,
    input  logic [DATA_W-1:0] wb0_rd_in,
    input  logic              wb1_write_en,
    input  logic [ADDR_W-1:0] wb1_rd_num,
    input  logic [DATA_W-1:0] wb1_rd_in,
    input  logic              wb_pc_write_en,
    input  logic [DATA_W-1:0] wb_pc_in,
    input  logic              wb_cpsr_write_en,
    input  logic [DATA_W-1:0] wb_cpsr_mask,
    input  logic [DATA_W-1:0] wb_cpsr_in
);
    localparam int NREG  = 2 ** ADDR_W;
    localparam int NREAD = 3;

    logic [DATA_W-1:0] regs_reg [NREG];
    logic [NREG-1:0]   busy_reg;
    logic [DATA_W-1:0] pc_reg;
    logic [DATA_W-1:0] cpsr_reg;
    logic [DATA_W-1:0] cpsr_next;

    logic [NREG-1:0] wr0_hit;
    logic [NREG-1:0] wr1_hit;
    logic [NREG-1:0] issue_hit;

    // Per-register decode of write and issue strobes; r0 is inert when hardwired
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_decode
            localparam bit LOCKED = ZERO_R0 && (gi == 0);
            assign wr0_hit[gi]   = !LOCKED && wb0_write_en && (wb0_rd_num == ADDR_W'(gi));
            assign wr1_hit[gi]   = !LOCKED && wb1_write_en && (wb1_rd_num == ADDR_W'(gi));
            assign issue_hit[gi] = !LOCKED && exe_issue_en && (exe_issue_num == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr1_hit[i]) begin
                    regs_reg[i] <= wb1_rd_in;
                end else if (wr0_hit[i]) begin
                    regs_reg[i] <= wb0_rd_in;
                end
                // A new producer issued in the same edge keeps the bit set
                if (issue_hit[i]) begin
                    busy_reg[i] <= 1'b1;
                end else if (wr0_hit[i] || wr1_hit[i]) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (wb_pc_write_en) begin
            pc_reg <= wb_pc_in;
        end else if (!if_stall) begin
            pc_reg <= pc_reg + PC_INC;
        end
    end

    assign cpsr_next = (cpsr_reg & ~wb_cpsr_mask) | (wb_cpsr_in & wb_cpsr_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            cpsr_reg <= '0;
        end else if (wb_cpsr_write_en) begin
            cpsr_reg <= cpsr_next;
        end
    end

    assign if_pc_out    = pc_reg;
    assign exe_cpsr_out = wb_cpsr_write_en ? cpsr_next : cpsr_reg;

    logic [NREAD-1:0][ADDR_W-1:0] read_num;
    logic [NREAD-1:0][DATA_W-1:0] read_data;
    logic [NREAD-1:0]             read_busy;

    assign read_num = {exe_rt_num, exe_rs_num, exe_rd_num};

    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_read
            logic [DATA_W-1:0] val;
            logic              zero_idx;

            assign zero_idx = ZERO_R0 && (read_num[gi] == '0);

            always_comb begin
                val = regs_reg[read_num[gi]];
                if (wb0_write_en && (wb0_rd_num == read_num[gi])) begin
                    val = wb0_rd_in;
                end
                if (wb1_write_en && (wb1_rd_num == read_num[gi])) begin
                    val = wb1_rd_in;
                end
                if (zero_idx) begin
                    val = '0;
                end
            end

            assign read_data[gi] = val;
            assign read_busy[gi] = !zero_idx && busy_reg[read_num[gi]];
        end
    endgenerate

    assign exe_rd_data_out = read_data[0];
    assign exe_rs_data_out = read_data[1];
    assign exe_rt_data_out = read_data[2];
    assign exe_rd_busy     = read_busy[0];
    assign exe_rs_busy     = read_busy[1];
    assign exe_rt_busy     = read_busy[2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expected values, a
// negedge monitor pops and compares those due in the current cycle.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_stall;
    logic [31:0] if_pc_out;
    logic [3:0]  exe_rd_num, exe_rs_num, exe_rt_num;
    logic [31:0] exe_rd_data_out, exe_rs_data_out, exe_rt_data_out;
    logic        exe_rd_busy, exe_rs_busy, exe_rt_busy;
    logic        exe_issue_en;
    logic [3:0]  exe_issue_num;
    logic [31:0] exe_cpsr_out;
    logic        wb0_write_en, wb1_write_en;
    logic [3:0]  wb0_rd_num, wb1_rd_num;
    logic [31:0] wb0_rd_in, wb1_rd_in;
    logic        wb_pc_write_en;
    logic [31:0] wb_pc_in;
    logic        wb_cpsr_write_en;
    logic [31:0] wb_cpsr_mask, wb_cpsr_in;

    logic [31:0] z_pc, z_rd, z_rs, z_rt, z_cpsr;
    logic        z_rd_busy, z_rs_busy, z_rt_busy;

    reg_file_mp dut (
        .clk(clk), .reset(reset), .if_stall(if_stall), .if_pc_out(if_pc_out),
        .exe_rd_num(exe_rd_num), .exe_rs_num(exe_rs_num), .exe_rt_num(exe_rt_num),
        .exe_rd_data_out(exe_rd_data_out), .exe_rs_data_out(exe_rs_data_out),
        .exe_rt_data_out(exe_rt_data_out),
        .exe_rd_busy(exe_rd_busy), .exe_rs_busy(exe_rs_busy), .exe_rt_busy(exe_rt_busy),
        .exe_issue_en(exe_issue_en), .exe_issue_num(exe_issue_num),
        .exe_cpsr_out(exe_cpsr_out),
        .wb0_write_en(wb0_write_en), .wb0_rd_num(wb0_rd_num), .wb0_rd_in(wb0_rd_in),
        .wb1_write_en(wb1_write_en), .wb1_rd_num(wb1_rd_num), .wb1_rd_in(wb1_rd_in),
        .wb_pc_write_en(wb_pc_write_en), .wb_pc_in(wb_pc_in),
        .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_mask(wb_cpsr_mask),
        .wb_cpsr_in(wb_cpsr_in)
    );

    reg_file_mp #(.ZERO_R0(1'b1)) dut_z (
        .clk(clk), .reset(reset), .if_stall(if_stall), .if_pc_out(z_pc),
        .exe_rd_num(exe_rd_num), .exe_rs_num(exe_rs_num), .exe_rt_num(exe_rt_num),
        .exe_rd_data_out(z_rd), .exe_rs_data_out(z_rs), .exe_rt_data_out(z_rt),
        .exe_rd_busy(z_rd_busy), .exe_rs_busy(z_rs_busy), .exe_rt_busy(z_rt_busy),
        .exe_issue_en(exe_issue_en), .exe_issue_num(exe_issue_num),
        .exe_cpsr_out(z_cpsr),
        .wb0_write_en(wb0_write_en), .wb0_rd_num(wb0_rd_num), .wb0_rd_in(wb0_rd_in),
        .wb1_write_en(wb1_write_en), .wb1_rd_num(wb1_rd_num), .wb1_rd_in(wb1_rd_in),
        .wb_pc_write_en(wb_pc_write_en), .wb_pc_in(wb_pc_in),
        .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_mask(wb_cpsr_mask),
        .wb_cpsr_in(wb_cpsr_in)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_PC, S_RD, S_RS, S_RT, S_RD_BUSY, S_RT_BUSY, S_CPSR, S_Z_RD, S_Z_RT, S_Z_RD_BUSY
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(sig_e s);
        case (s)
            S_PC:        return if_pc_out;
            S_RD:        return exe_rd_data_out;
            S_RS:        return exe_rs_data_out;
            S_RT:        return exe_rt_data_out;
            S_RD_BUSY:   return {31'd0, exe_rd_busy};
            S_RT_BUSY:   return {31'd0, exe_rt_busy};
            S_CPSR:      return exe_cpsr_out;
            S_Z_RD:      return z_rd;
            S_Z_RT:      return z_rt;
            S_Z_RD_BUSY: return {31'd0, z_rd_busy};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = get_sig(e.sig);
            total++;
            if (e.cyc != cyc || act !== e.exp) begin
                bad++;
                $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h (due cycle %0d)",
                         e.name, cyc, act, e.exp, e.cyc);
            end else begin
                $display("ok   %s: cycle %0d value 0x%08h", e.name, cyc, act);
            end
        end
    end

    task automatic push(input int c, input sig_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = c; e.sig = s; e.exp = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic expect_now(input sig_e s, input logic [31:0] v, input string n);
        push(cyc, s, v, n);
    endtask

    task automatic expect_next(input sig_e s, input logic [31:0] v, input string n);
        push(cyc + 1, s, v, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; if_stall = 1'b0;
        exe_rd_num = '0; exe_rs_num = '0; exe_rt_num = '0;
        exe_issue_en = 1'b0; exe_issue_num = '0;
        wb0_write_en = 1'b0; wb0_rd_num = '0; wb0_rd_in = '0;
        wb1_write_en = 1'b0; wb1_rd_num = '0; wb1_rd_in = '0;
        wb_pc_write_en = 1'b0; wb_pc_in = '0;
        wb_cpsr_write_en = 1'b0; wb_cpsr_mask = '0; wb_cpsr_in = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        // Reset held for two edges
        expect_now(S_PC, 32'd0, "reset_pc");
        expect_now(S_CPSR, 32'd0, "reset_cpsr");
        expect_now(S_RD, 32'd0, "reset_rd");
        expect_now(S_RD_BUSY, 32'd0, "reset_busy");
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            expect_next(S_PC, 32'(k), "pc_count");
            step();
        end

        // Stall at PC=5, then branch load while stalled
        if_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_now(S_PC, 32'd5, "pc_stall");
            step();
        end
        wb_pc_write_en = 1'b1; wb_pc_in = 32'd40;
        expect_now(S_PC, 32'd5, "pc_before_load");
        expect_next(S_PC, 32'd40, "pc_load_stalled");
        step();
        if_stall = 1'b0;
        wb_pc_in = 32'hFFFF_FFFF;
        expect_next(S_PC, 32'hFFFF_FFFF, "pc_preload");
        step();
        wb_pc_write_en = 1'b0;
        expect_next(S_PC, 32'd0, "pc_wrap");
        step();

        // Both WB ports on r3: port 1 wins, bypassed and stored
        wb0_write_en = 1'b1; wb0_rd_num = 4'd3; wb0_rd_in = 32'hA;
        wb1_write_en = 1'b1; wb1_rd_num = 4'd3; wb1_rd_in = 32'hB;
        exe_rs_num = 4'd3;
        expect_now(S_RS, 32'hB, "dual_same_bypass");
        step();
        wb0_rd_num = 4'd4; wb0_rd_in = 32'd7;
        wb1_rd_num = 4'd5; wb1_rd_in = 32'd9;
        expect_now(S_RS, 32'hB, "dual_same_stored");
        step();
        wb0_write_en = 1'b0; wb1_write_en = 1'b0;
        exe_rd_num = 4'd4; exe_rs_num = 4'd5;
        expect_now(S_RD, 32'd7, "dual_r4");
        expect_now(S_RS, 32'd9, "dual_r5");
        step();

        // Bypass sweep, alternating ports; r0 stays 0 in the hardwired instance
        for (int i = 0; i < 16; i++) begin
            wb0_write_en = (i % 2 == 0); wb0_rd_num = 4'(i); wb0_rd_in = 32'(i) + 32'h100;
            wb1_write_en = (i % 2 == 1); wb1_rd_num = 4'(i); wb1_rd_in = 32'(i) + 32'h100;
            exe_rd_num = 4'(i); exe_rs_num = 4'(i); exe_rt_num = 4'(i);
            expect_now(S_RD, 32'(i) + 32'h100, "sweep_rd");
            expect_now(S_RS, 32'(i) + 32'h100, "sweep_rs");
            expect_now(S_RT, 32'(i) + 32'h100, "sweep_rt");
            expect_now(S_Z_RT, (i == 0) ? 32'd0 : 32'(i) + 32'h100, "sweep_z_rt");
            step();
        end
        wb0_write_en = 1'b0; wb1_write_en = 1'b0;
        exe_rd_num = 4'd0; exe_rt_num = 4'd9;
        expect_now(S_RD, 32'h100, "stored_r0");
        expect_now(S_Z_RD, 32'd0, "stored_z_r0");
        expect_now(S_RT, 32'h109, "stored_r9");
        step();

        // CPSR masked merge, bypassed during the write cycle
        wb_cpsr_write_en = 1'b1; wb_cpsr_mask = 32'hFF; wb_cpsr_in = 32'hF0;
        step();
        wb_cpsr_mask = 32'h3C; wb_cpsr_in = 32'h0F;
        expect_now(S_CPSR, 32'hCC, "cpsr_bypass");
        step();
        wb_cpsr_write_en = 1'b0;
        expect_now(S_CPSR, 32'hCC, "cpsr_stored");
        step();

        // Scoreboard on r7, plus an issue to r0 that only the normal instance records
        exe_issue_en = 1'b1; exe_issue_num = 4'd7; exe_rt_num = 4'd7;
        expect_now(S_RT_BUSY, 32'd0, "busy_before_issue");
        expect_next(S_RT_BUSY, 32'd1, "busy_after_issue");
        step();
        wb0_write_en = 1'b1; wb0_rd_num = 4'd7; wb0_rd_in = 32'h77;
        expect_now(S_RT_BUSY, 32'd1, "busy_no_clear_bypass");
        expect_next(S_RT_BUSY, 32'd1, "busy_reissue_holds");
        step();
        exe_issue_en = 1'b0; wb0_write_en = 1'b0;
        wb1_write_en = 1'b1; wb1_rd_num = 4'd7; wb1_rd_in = 32'h78;
        expect_now(S_RT_BUSY, 32'd1, "busy_clear_pending");
        expect_next(S_RT_BUSY, 32'd0, "busy_cleared");
        step();
        wb1_write_en = 1'b0;
        exe_issue_en = 1'b1; exe_issue_num = 4'd0; exe_rd_num = 4'd0;
        expect_next(S_RD_BUSY, 32'd1, "busy_r0");
        expect_next(S_Z_RD_BUSY, 32'd0, "busy_z_r0");
        step();
        exe_issue_num = 4'd7;
        expect_next(S_RT_BUSY, 32'd1, "busy_again");
        expect_next(S_RT, 32'h78, "r7_value");
        step();

        // Reset while busy, with an issue and writes in flight
        reset = 1'b1;
        wb_pc_write_en = 1'b1; wb_pc_in = 32'h1234;
        wb_cpsr_write_en = 1'b1; wb_cpsr_mask = 32'hFFFF_FFFF; wb_cpsr_in = 32'h55;
        step();
        wb_pc_write_en = 1'b0; wb_cpsr_write_en = 1'b0; exe_issue_en = 1'b0;
        expect_now(S_RT_BUSY, 32'd0, "reset_clears_busy");
        expect_now(S_RD_BUSY, 32'd0, "reset_clears_busy_r0");
        expect_now(S_PC, 32'd0, "reset_pc_over_load");
        expect_now(S_CPSR, 32'd0, "reset_cpsr_over_write");
        expect_now(S_RT, 32'd0, "reset_clears_r7");
        step();
        reset = 1'b0;
        step();
        step();
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        @(posedge clk);
        total++;
        if (!stim_done || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: stim_done=%0d pending=%0d required done=1 pending=0",
                     stim_done, exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
